// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: parametrised single-clock first-word-fall-through FIFO with count, flags, flush and error pulses
module sync_fifo_fwft #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count_nxt;
  logic wr_acc, rd_acc;
  // flush suppresses both operations so neither storage nor the error pulses see them
  always_comb begin
    wr_acc    = !flush && wr_en && (!full || rd_en);
    rd_acc    = !flush && rd_en && !empty;
    count_nxt = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + (AW+1)'(wr_acc);
      rd_ptr       <= rd_ptr + (AW+1)'(rd_acc);
      count        <= count_nxt;
      empty        <= count_nxt == '0;
      full         <= count_nxt == (AW+1)'(DEPTH);
      almost_full  <= count_nxt >= (AW+1)'(AFULL_THRESH);
      almost_empty <= count_nxt <= (AW+1)'(AEMPTY_THRESH);
      overflow     <= wr_en && full && !rd_en;
      underflow    <= rd_en && empty;
    end
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed self-checking bench for sync_fifo_fwft (32x16, afull 12, aempty 2)
module tb_sync_fifo_fwft;
  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int vecs = 0, errs = 0;

  sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h900 + i, 0, 0);
    vecs++; if (count !== 5'd3) begin errs++; $display("FAIL pre_reset_count got %0d want 3", count); end
    wr_en = 1; wr_data = 32'h999; rst = 1; #1;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL reset_aempty got %b want 1", almost_empty); end
    vecs++; if (almost_full !== 1'b0) begin errs++; $display("FAIL reset_afull got %b want 0", almost_full); end
    vecs++; if (rd_data !== 32'h0) begin errs++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    vecs++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errs++; $display("FAIL reset_pulses got %b%b want 00", overflow, underflow); end
    @(posedge clk); #1;
    wr_en = 0; rst = 0;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 32'h100 + i, 0, 0);
      vecs++; if (count !== 5'(i + 1)) begin errs++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      vecs++; if (almost_full !== (i + 1 >= 12)) begin errs++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, i + 1 >= 12); end
      vecs++; if (almost_empty !== (i + 1 <= 2)) begin errs++; $display("FAIL fill_aempty[%0d] got %b want %b", i, almost_empty, i + 1 <= 2); end
      vecs++; if (full !== (i == 15)) begin errs++; $display("FAIL fill_full[%0d] got %b want %b", i, full, i == 15); end
      vecs++; if (rd_data !== 32'h100) begin errs++; $display("FAIL fill_head[%0d] got %h want 100", i, rd_data); end
    end
    step(1, 32'hBAD, 0, 0);
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL overflow_pulse got %b want 1", overflow); end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL overflow_count got %0d want 16", count); end
    step(0, 0, 0, 0);
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL overflow_clear got %b want 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      vecs++; if (rd_data !== 32'h100 + i) begin errs++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, 32'h100 + i); end
      step(0, 0, 1, 0);
      vecs++; if (count !== 5'(15 - i)) begin errs++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 15 - i); end
      vecs++; if (empty !== (i == 15)) begin errs++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty, i == 15); end
    end
    vecs++; if (rd_data !== 32'h0) begin errs++; $display("FAIL empty_rd_data got %h want 0", rd_data); end
    step(0, 0, 1, 0);
    vecs++; if (underflow !== 1'b1) begin errs++; $display("FAIL underflow_pulse got %b want 1", underflow); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL underflow_count got %0d want 0", count); end
    step(0, 0, 0, 0);
    vecs++; if (underflow !== 1'b0) begin errs++; $display("FAIL underflow_clear got %b want 0", underflow); end
  endtask

  task automatic test_full_pass();
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'h200 + i, 0, 0);
    step(1, 32'hAAAA, 1, 0);
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL pass_count got %0d want 16", count); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL pass_overflow got %b want 0", overflow); end
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL pass_full got %b want 1", full); end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (rd_data !== (i == 15 ? 32'hAAAA : 32'h201 + i)) begin
        errs++; $display("FAIL pass_data[%0d] got %h want %h", i, rd_data, i == 15 ? 32'hAAAA : 32'h201 + i);
      end
      step(0, 0, 1, 0);
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL pass_empty got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic w, r;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h300 + i, 0, 0);
      q.push_back(32'h300 + i);
    end
    for (int i = 0; i < 40; i++) begin
      w = q.size() <= 3 ? 1'b1 : q.size() >= 10 ? 1'b0 : 1'($urandom_range(0, 1));
      r = q.size() >= 10 ? 1'b1 : q.size() <= 3 ? 1'b0 : 1'($urandom_range(0, 1));
      d = $urandom;
      vecs++; if (rd_data !== q[0]) begin errs++; $display("FAIL wrap_data[%0d] got %h want %h", i, rd_data, q[0]); end
      step(w, d, r, 0);
      if (r) void'(q.pop_front());
      if (w) q.push_back(d);
      vecs++; if (count !== 5'(q.size())) begin errs++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count, q.size()); end
    end
  endtask

  task automatic test_fwft();
    do_reset();
    step(1, 32'hDEAD, 0, 0);
    vecs++; if (rd_data !== 32'hDEAD) begin errs++; $display("FAIL fwft_data got %h want dead", rd_data); end
    vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL fwft_empty got %b want 0", empty); end
    step(0, 0, 1, 0);
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL fwft_drained got %b want 1", empty); end
    step(1, 32'hBEEF, 1, 0);
    vecs++; if (underflow !== 1'b1) begin errs++; $display("FAIL wr_rd_empty_underflow got %b want 1", underflow); end
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL wr_rd_empty_count got %0d want 1", count); end
    vecs++; if (rd_data !== 32'hBEEF) begin errs++; $display("FAIL wr_rd_empty_data got %h want beef", rd_data); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 32'h400 + i, 0, 0);
    vecs++; if (count !== 5'd7) begin errs++; $display("FAIL preflush_count got %0d want 7", count); end
    step(1, 32'h77, 1, 1);
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL flush_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL flush_empty got %b want 1", empty); end
    vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL flush_aempty got %b want 1", almost_empty); end
    vecs++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errs++; $display("FAIL flush_pulses got %b%b want 00", overflow, underflow); end
    vecs++; if (rd_data !== 32'h0) begin errs++; $display("FAIL flush_rd_data got %h want 0", rd_data); end
    step(1, 32'h55, 0, 0);
    vecs++; if (rd_data !== 32'h55) begin errs++; $display("FAIL postflush_data got %h want 55", rd_data); end
    step(0, 0, 1, 0);
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL postflush_empty got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_pass();
    test_wrap();
    test_fwft();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
